// File: rtl/text_pkg.sv
// Shared cell-word layout, the blank cell written by the clear sweep, and
// the host-side FSM state type for the text renderer.
package text_pkg;

  localparam int CELL_W    = 15;
  localparam int CHAR_LSB  = 0;
  localparam int CHAR_W    = 8;
  localparam int FG_LSB    = 8;
  localparam int BG_LSB    = 11;
  localparam int COLOR_W   = 3;
  localparam int BLINK_BIT = 14;

  // Space character, white on black, not blinking.
  localparam logic [CELL_W-1:0] CLEAR_CELL = {1'b0, 3'b000, 3'b111, 8'h20};

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/glyph_rom.sv
// Shared 1-bit glyph ROM for 8x16 glyphs: addr = {char, gy, gx}, one
// registered bit out. Leftmost pixel of a glyph row is bit 7.
module glyph_rom (
  input  logic        clk,
  input  logic [14:0] addr,
  output logic        rd_bit
);

  function automatic logic [7:0] glyph_row(input logic [7:0] ch, input logic [3:0] r);
    glyph_row = 8'h00;
    if (ch == 8'h41) begin
      case (r)
        4'd2:    glyph_row = 8'h10;
        4'd3:    glyph_row = 8'h38;
        4'd4:    glyph_row = 8'h6C;
        4'd5,
        4'd6:    glyph_row = 8'hC6;
        4'd7:    glyph_row = 8'hFE;
        4'd8,
        4'd9,
        4'd10,
        4'd11:   glyph_row = 8'hC6;
        default: glyph_row = 8'h00;
      endcase
    end
  endfunction

  logic [7:0] row_bits;

  always_comb row_bits = glyph_row(addr[14:7], addr[6:3]);

  always_ff @(posedge clk) begin
    rd_bit <= row_bits[3'd7 - addr[2:0]];
  end

endmodule

// File: rtl/text_renderer_cell_ram.sv
// Dual-port cell RAM: port A write-only, port B synchronous read that
// returns the old word when both ports hit the same cell in one cycle.
module cell_ram #(
  parameter int DEPTH  = 2400,
  parameter int WIDTH  = 15,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_data <= mem_q[rd_addr];
  end

endmodule

// File: rtl/text_renderer.sv
// Text-mode pixel generator: scan coordinate -> cell RAM -> glyph ROM ->
// coloured pixel, 3-cycle pipeline, with host write port and clear sweep.
module text_renderer
  import text_pkg::*;
#(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 16,
  parameter int BLINK_FRAMES = 30,
  parameter int ADDR_W       = $clog2(COLS*ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              de,
  input  logic              frame_start,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [14:0]       host_data,
  input  logic              clear,
  input  logic              cursor_en,
  input  logic [6:0]        cursor_col,
  input  logic [4:0]        cursor_row,
  output logic [2:0]        o_pixel,
  output logic              o_de
);

  localparam int TOTAL = COLS * ROWS;
  localparam int GXW   = $clog2(GLYPH_W);
  localparam int GYW   = $clog2(GLYPH_H);
  localparam int GA_W  = CHAR_W + GYW + GXW;
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              ready_q, ready_d;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      S_CLEAR: begin
        if (clr_addr_q == ADDR_W'(TOTAL - 1)) state_d = S_IDLE;
        else clr_addr_d = clr_addr_q + ADDR_W'(1);
      end
      S_IDLE: begin
        if (clear) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
        end
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      ready_q    <= ready_d;
    end
  end

  assign host_ready = ready_q;

  // Port A belongs to the sweep while clearing, to the host otherwise.
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CELL_W-1:0] wr_data;

  always_comb begin
    if (state_q == S_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr_q;
      wr_data = CLEAR_CELL;
    end else begin
      wr_en   = host_valid && ready_q && (int'(host_addr) < TOTAL);
      wr_addr = host_addr;
      wr_data = host_data;
    end
  end

  logic [9:0]        col, row;
  logic [ADDR_W-1:0] rd_addr;
  logic              s1_valid_d, s1_de_d, s1_cursor_d;
  logic              s1_valid_q, s1_de_q, s1_cursor_q;
  logic [GXW-1:0]    s1_gx_q;
  logic [GYW-1:0]    s1_gy_q;
  logic [CELL_W-1:0] cell_rd;

  always_comb begin
    col         = x >> GXW;
    row         = y >> GYW;
    rd_addr     = ADDR_W'(int'(row) * COLS + int'(col));
    s1_valid_d  = de && (int'(x) < COLS * GLYPH_W) && (int'(y) < ROWS * GLYPH_H);
    s1_de_d     = de;
    s1_cursor_d = cursor_en && (int'(col) == int'(cursor_col)) && (int'(row) == int'(cursor_row));
  end

  cell_ram #(
    .DEPTH  (TOTAL),
    .WIDTH  (CELL_W),
    .ADDR_W (ADDR_W)
  ) u_cell_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (cell_rd)
  );

  logic [GA_W-1:0]    glyph_addr;
  logic               glyph_bit;
  logic [COLOR_W-1:0] s2_fg_q, s2_bg_q;
  logic               s2_blink_q, s2_cursor_q, s2_valid_q, s2_de_q;

  // Power-of-two glyph sizes make char*W*H + gy*W + gx a plain concatenation.
  assign glyph_addr = {cell_rd[CHAR_LSB +: CHAR_W], s1_gy_q, s1_gx_q};

  glyph_rom u_glyph_rom (
    .clk    (clk),
    .addr   (glyph_addr),
    .rd_bit (glyph_bit)
  );

  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            blink_phase_q, blink_phase_d;
  logic            pix_bit;
  logic [2:0]      pixel_d;

  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_start) begin
      if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end
    pix_bit = glyph_bit && !(s2_blink_q && blink_phase_q);
    if (s2_cursor_q && !blink_phase_q) pix_bit = !pix_bit;
    pixel_d = s2_valid_q ? (pix_bit ? s2_fg_q : s2_bg_q) : 3'b000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_de_q       <= 1'b0;
      s1_cursor_q   <= 1'b0;
      s1_gx_q       <= '0;
      s1_gy_q       <= '0;
      s2_fg_q       <= '0;
      s2_bg_q       <= '0;
      s2_blink_q    <= 1'b0;
      s2_cursor_q   <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_de_q       <= 1'b0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      o_pixel       <= 3'b000;
      o_de          <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_de_q       <= s1_de_d;
      s1_cursor_q   <= s1_cursor_d;
      s1_gx_q       <= x[GXW-1:0];
      s1_gy_q       <= y[GYW-1:0];
      s2_fg_q       <= cell_rd[FG_LSB +: COLOR_W];
      s2_bg_q       <= cell_rd[BG_LSB +: COLOR_W];
      s2_blink_q    <= cell_rd[BLINK_BIT];
      s2_cursor_q   <= s1_cursor_q;
      s2_valid_q    <= s1_valid_q;
      s2_de_q       <= s1_de_q;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      o_pixel       <= pixel_d;
      o_de          <= s2_de_q;
    end
  end

endmodule

// File: tb/tb_text_renderer.sv
// Directed bench for text_renderer: clear sweeps, host writes, glyph
// rendering, blink, cursor, visibility limits and pipeline latency.
module tb_text_renderer;

  logic        clk;
  logic        rst;
  logic [9:0]  x, y;
  logic        de;
  logic        frame_start;
  logic        host_valid;
  logic        host_ready;
  logic [11:0] host_addr;
  logic [14:0] host_data;
  logic        clear;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [2:0]  o_pixel;
  logic        o_de;

  int n_checks = 0;
  int n_fail   = 0;

  text_renderer #(
    .COLS         (80),
    .ROWS         (30),
    .GLYPH_W      (8),
    .GLYPH_H      (16),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .x           (x),
    .y           (y),
    .de          (de),
    .frame_start (frame_start),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_addr   (host_addr),
    .host_data   (host_data),
    .clear       (clear),
    .cursor_en   (cursor_en),
    .cursor_col  (cursor_col),
    .cursor_row  (cursor_row),
    .o_pixel     (o_pixel),
    .o_de        (o_de)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-entered bitmap of 'A' (leftmost pixel = bit 7).
  function automatic logic [7:0] font_a_row(input int r);
    case (r)
      2:                  return 8'h10;
      3:                  return 8'h38;
      4:                  return 8'h6C;
      5, 6:               return 8'hC6;
      7:                  return 8'hFE;
      8, 9, 10, 11:       return 8'hC6;
      default:            return 8'h00;
    endcase
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic show(input int px, input int py, input logic pde);
    x  = 10'(px);
    y  = 10'(py);
    de = pde;
    repeat (3) tick();
  endtask

  task automatic host_write(input int a, input logic [14:0] d);
    host_addr  = 12'(a);
    host_data  = d;
    host_valid = 1'b1;
    n_checks++;
    if (host_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL write_ready addr %0d: host_ready %b required 1", a, host_ready);
    end
    tick();
    host_valid = 1'b0;
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    int rise;
    rst         = 1'b1;
    frame_start = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (o_pixel !== 3'b000) begin n_fail++; $display("FAIL reset_pixel: got %b required 000", o_pixel); end
    n_checks++;
    if (o_de !== 1'b0) begin n_fail++; $display("FAIL reset_de: got %b required 0", o_de); end
    n_checks++;
    if (host_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b required 0", host_ready); end
    frame_start = 1'b0;
    rst         = 1'b0;
    rise        = -1;
    for (int n = 1; n <= 2400; n++) begin
      tick();
      if (host_ready === 1'b1 && rise < 0) rise = n;
    end
    n_checks++;
    if (rise != 2400) begin n_fail++; $display("FAIL reset_sweep_len: ready rose at cycle %0d required 2400", rise); end
  endtask

  task automatic test_clear_scan();
    for (int yy = 0; yy < 480; yy += 23) begin
      for (int xx = 0; xx < 640; xx += 37) begin
        show(xx, yy, 1'b1);
        n_checks++;
        if (o_pixel !== 3'b000) begin
          n_fail++;
          $display("FAIL clear_scan(%0d,%0d): got %b required 000", xx, yy, o_pixel);
        end
      end
    end
    n_checks++;
    if (o_de !== 1'b1) begin n_fail++; $display("FAIL clear_scan_de: got %b required 1", o_de); end
  endtask

  task automatic test_single_write();
    logic [7:0] row;
    logic [2:0] exp;
    host_write(81, {1'b0, 3'b001, 3'b100, 8'h41});
    for (int gy = 0; gy < 16; gy++) begin
      row = font_a_row(gy);
      for (int gx = 0; gx < 8; gx++) begin
        show(8 + gx, 16 + gy, 1'b1);
        exp = row[7 - gx] ? 3'b100 : 3'b001;
        n_checks++;
        if (o_pixel !== exp) begin
          n_fail++;
          $display("FAIL single_write(%0d,%0d): got %b required %b", 8 + gx, 16 + gy, o_pixel, exp);
        end
      end
    end
  endtask

  task automatic test_latency();
    show(8, 16, 1'b1);
    x = 10'd8;
    y = 10'd23;
    tick();
    tick();
    n_checks++;
    if (o_pixel !== 3'b001) begin n_fail++; $display("FAIL latency_2cyc: got %b required 001", o_pixel); end
    tick();
    n_checks++;
    if (o_pixel !== 3'b100) begin n_fail++; $display("FAIL latency_3cyc: got %b required 100", o_pixel); end
    de = 1'b0;
    tick();
    tick();
    n_checks++;
    if (o_de !== 1'b1) begin n_fail++; $display("FAIL de_latency_2cyc: got %b required 1", o_de); end
    tick();
    n_checks++;
    if (o_de !== 1'b0) begin n_fail++; $display("FAIL de_latency_3cyc: got %b required 0", o_de); end
  endtask

  task automatic test_blink();
    logic [2:0] exp;
    host_write(0, {1'b1, 3'b010, 3'b110, 8'h41});
    for (int f = 0; f <= 4; f++) begin
      exp = (f == 2 || f == 3) ? 3'b010 : 3'b110;
      show(0, 7, 1'b1);
      n_checks++;
      if (o_pixel !== exp) begin n_fail++; $display("FAIL blink_frame%0d: got %b required %b", f, o_pixel, exp); end
      show(0, 0, 1'b1);
      n_checks++;
      if (o_pixel !== 3'b010) begin n_fail++; $display("FAIL blink_bg_frame%0d: got %b required 010", f, o_pixel); end
      if (f < 4) frame_pulse();
    end
  endtask

  task automatic test_cursor();
    cursor_en  = 1'b1;
    cursor_col = 7'd5;
    cursor_row = 5'd2;
    show(43, 36, 1'b1);
    n_checks++;
    if (o_pixel !== 3'b111) begin n_fail++; $display("FAIL cursor_phase0: got %b required 111", o_pixel); end
    show(51, 36, 1'b1);
    n_checks++;
    if (o_pixel !== 3'b000) begin n_fail++; $display("FAIL cursor_next_col: got %b required 000", o_pixel); end
    show(43, 52, 1'b1);
    n_checks++;
    if (o_pixel !== 3'b000) begin n_fail++; $display("FAIL cursor_next_row: got %b required 000", o_pixel); end
    frame_pulse();
    frame_pulse();
    show(43, 36, 1'b1);
    n_checks++;
    if (o_pixel !== 3'b000) begin n_fail++; $display("FAIL cursor_phase1: got %b required 000", o_pixel); end
    frame_pulse();
    frame_pulse();
    show(43, 36, 1'b1);
    n_checks++;
    if (o_pixel !== 3'b111) begin n_fail++; $display("FAIL cursor_phase0_again: got %b required 111", o_pixel); end
    cursor_en = 1'b0;
    show(43, 36, 1'b1);
    n_checks++;
    if (o_pixel !== 3'b000) begin n_fail++; $display("FAIL cursor_disabled: got %b required 000", o_pixel); end
  endtask

  task automatic test_boundaries();
    host_write(2399, {1'b0, 3'b111, 3'b000, 8'h20});
    show(639, 479, 1'b1);
    n_checks++;
    if (o_pixel !== 3'b111) begin n_fail++; $display("FAIL last_cell: got %b required 111", o_pixel); end
    show(640, 479, 1'b1);
    n_checks++;
    if (o_pixel !== 3'b000) begin n_fail++; $display("FAIL x_640: got %b required 000", o_pixel); end
    show(639, 480, 1'b1);
    n_checks++;
    if (o_pixel !== 3'b000) begin n_fail++; $display("FAIL y_480: got %b required 000", o_pixel); end
    show(8, 23, 1'b0);
    n_checks++;
    if (o_pixel !== 3'b000) begin n_fail++; $display("FAIL de_low_pixel: got %b required 000", o_pixel); end
    n_checks++;
    if (o_de !== 1'b0) begin n_fail++; $display("FAIL de_low_de: got %b required 0", o_de); end
    host_write(2400, {1'b0, 3'b111, 3'b111, 8'h41});
    show(0, 7, 1'b1);
    n_checks++;
    if (o_pixel !== 3'b110) begin n_fail++; $display("FAIL addr2400_cell0: got %b required 110", o_pixel); end
    show(639, 479, 1'b1);
    n_checks++;
    if (o_pixel !== 3'b111) begin n_fail++; $display("FAIL addr2400_cell2399: got %b required 111", o_pixel); end
    show(8, 23, 1'b1);
    n_checks++;
    if (o_pixel !== 3'b100) begin n_fail++; $display("FAIL addr2400_cell81: got %b required 100", o_pixel); end
  endtask

  task automatic test_clear_handshake();
    int rise;
    clear = 1'b1;
    tick();
    clear      = 1'b0;
    host_addr  = 12'd81;
    host_data  = {1'b0, 3'b000, 3'b010, 8'h41};
    host_valid = 1'b1;
    rise       = -1;
    for (int n = 1; n <= 2400; n++) begin
      clear = (n == 1000);
      tick();
      if (host_ready === 1'b1 && rise < 0) rise = n;
    end
    clear = 1'b0;
    n_checks++;
    if (rise != 2400) begin n_fail++; $display("FAIL clear_hold_off: ready rose at cycle %0d required 2400", rise); end
    tick();
    host_valid = 1'b0;
    show(8, 23, 1'b1);
    n_checks++;
    if (o_pixel !== 3'b010) begin n_fail++; $display("FAIL post_clear_write: got %b required 010", o_pixel); end
    show(0, 7, 1'b1);
    n_checks++;
    if (o_pixel !== 3'b000) begin n_fail++; $display("FAIL post_clear_cell0: got %b required 000", o_pixel); end
    show(639, 479, 1'b1);
    n_checks++;
    if (o_pixel !== 3'b000) begin n_fail++; $display("FAIL post_clear_cell2399: got %b required 000", o_pixel); end
  endtask

  task automatic test_reset_mid_sweep();
    int rise;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    show(8, 23, 1'b1);
    repeat (997) tick();
    rst         = 1'b1;
    frame_start = 1'b1;
    tick();
    tick();
    n_checks++;
    if (o_pixel !== 3'b000 || o_de !== 1'b0) begin
      n_fail++;
      $display("FAIL midsweep_reset_out: pixel %b de %b required 000/0", o_pixel, o_de);
    end
    n_checks++;
    if (host_ready !== 1'b0) begin n_fail++; $display("FAIL midsweep_reset_ready: got %b required 0", host_ready); end
    rst         = 1'b0;
    frame_start = 1'b0;
    rise        = -1;
    for (int n = 1; n <= 2400; n++) begin
      tick();
      if (host_ready === 1'b1 && rise < 0) rise = n;
    end
    n_checks++;
    if (rise != 2400) begin n_fail++; $display("FAIL midsweep_len: ready rose at cycle %0d required 2400", rise); end
    show(8, 23, 1'b1);
    n_checks++;
    if (o_pixel !== 3'b000) begin n_fail++; $display("FAIL midsweep_cell81: got %b required 000", o_pixel); end
    host_write(0, {1'b1, 3'b010, 3'b110, 8'h41});
    show(0, 7, 1'b1);
    n_checks++;
    if (o_pixel !== 3'b110) begin n_fail++; $display("FAIL frame_start_in_reset: got %b required 110", o_pixel); end
  endtask

  initial begin
    rst         = 1'b0;
    x           = '0;
    y           = '0;
    de          = 1'b0;
    frame_start = 1'b0;
    host_valid  = 1'b0;
    host_addr   = '0;
    host_data   = '0;
    clear       = 1'b0;
    cursor_en   = 1'b0;
    cursor_col  = '0;
    cursor_row  = '0;
    #3;
    test_reset();
    test_clear_scan();
    test_single_write();
    test_latency();
    test_blink();
    test_cursor();
    test_boundaries();
    test_clear_handshake();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
